crc16_frame_ctrl: RTL and testbench

- Frame-level sequencer for the crc16_parallel engine.
- Accepts 16-bit words on a valid/ready stream with a last flag and drives engine clear, enable and data.
- At end of frame, returns the CRC on a result handshake.
- Two modes: generate (CRC over all words) and check (final word is the expected CRC, compared against the CRC of the preceding words). The engine stays external.

---
 rtl/crc16_ctrl_pkg.sv | 15 +
 rtl/crc16_frame_ctrl.sv | 118 +++++++++++
 tb/tb_crc16_frame_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/crc16_ctrl_pkg.sv
// Shared constants and FSM state encoding for the CRC16 frame controller.
package crc16_ctrl_pkg;

  localparam int   CRC_W    = 16;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/crc16_frame_ctrl.sv
// Frame sequencer for an external crc16_parallel engine: feeds words, then
// returns the frame CRC (generate mode) or a pass/fail verdict (check mode).
module crc16_frame_ctrl
  import crc16_ctrl_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CRC_W-1:0] s_data,
  input  logic             s_last,
  input  logic             mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CRC_W-1:0] m_crc,
  output logic             m_err,
  output logic             eng_clear,
  output logic             eng_enable,
  output logic [CRC_W-1:0] eng_data,
  input  logic [CRC_W-1:0] eng_crc,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               LEN_W   = $clog2(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_WORDS);

  state_t             r_state;
  logic [LEN_W-1:0]   r_count;
  logic               r_ovf;
  logic               r_started;
  logic               r_mode;
  logic [CRC_W-1:0]   r_exp;
  logic [CRC_W-1:0]   r_crc;
  logic               r_err;
  logic [CNT_W-1:0]   r_frameCnt;
  logic [CNT_W-1:0]   r_errCnt;

  logic w_accept;
  logic w_beat;
  logic w_modeEff;
  logic w_chkLast;
  logic w_fed;
  logic w_ovfHit;

  // Mode is taken live on the first beat so single-word frames see it too.
  assign w_accept  = (r_state == ST_ACCEPT);
  assign w_beat    = s_valid & w_accept;
  assign w_modeEff = r_started ? r_mode : mode;
  assign w_chkLast = w_beat & s_last & (w_modeEff == MODE_CHK);
  assign w_fed     = w_beat & (r_count < MAX_CNT) & ~w_chkLast;
  assign w_ovfHit  = w_beat & ~w_fed & (r_count == MAX_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_started  <= 1'b0;
      r_mode     <= MODE_GEN;
      r_exp      <= '0;
      r_crc      <= '0;
      r_err      <= 1'b0;
      r_frameCnt <= '0;
      r_errCnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_count   <= '0;
          r_ovf     <= 1'b0;
          r_started <= 1'b0;
          r_exp     <= '0;
          r_state   <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (w_beat) begin
            r_started <= 1'b1;
            if (!r_started) r_mode <= mode;
            if (w_fed)      r_count <= r_count + 1'b1;
            if (w_ovfHit)   r_ovf <= 1'b1;
            if (w_chkLast)  r_exp <= s_data;
            if (s_last)     r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // eng_crc has absorbed the final fed word by now.
          r_crc   <= eng_crc;
          r_err   <= r_ovf | ((r_mode == MODE_CHK) & (eng_crc != r_exp));
          r_state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (m_ready) begin
            r_frameCnt <= r_frameCnt + 1'b1;
            r_errCnt   <= r_errCnt + CNT_W'(r_err);
            r_state    <= ST_CLEAR;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign s_ready    = w_accept;
  assign m_valid    = (r_state == ST_RESULT);
  assign m_crc      = r_crc;
  assign m_err      = r_err;
  assign eng_clear  = (r_state == ST_CLEAR);
  assign eng_enable = w_fed;
  assign eng_data   = s_data;
  assign busy       = (r_state == ST_SETTLE) | (r_state == ST_RESULT) | (w_accept & r_started);
  assign frame_cnt  = r_frameCnt;
  assign err_cnt    = r_errCnt;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed bench for crc16_frame_ctrl using an XOR stub engine; a second
// instance with MAX_WORDS=4 shares the stimulus for the overflow case.
module tb_crc16_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sValid = 1'b0;
  logic [15:0] sData = '0;
  logic        sLast = 1'b0;
  logic        mode = 1'b0;
  logic        mReady = 1'b0;

  logic        sReady, mValid, mErr, engClear, engEnable, busy;
  logic [15:0] mCrc, engData;
  logic [15:0] engCrc;
  logic [15:0] frameCnt, errCnt;

  logic        sReady4, mValid4, mErr4, engClear4, engEnable4, busy4;
  logic [15:0] mCrc4, engData4;
  logic [15:0] engCrc4;
  logic [15:0] frameCnt4, errCnt4;

  int checks = 0;
  int errors = 0;
  int enCount4 = 0;

  always #5 clk = ~clk;

  crc16_frame_ctrl dut (
    .clk(clk), .reset(reset),
    .s_valid(sValid), .s_ready(sReady), .s_data(sData), .s_last(sLast), .mode(mode),
    .m_valid(mValid), .m_ready(mReady), .m_crc(mCrc), .m_err(mErr),
    .eng_clear(engClear), .eng_enable(engEnable), .eng_data(engData), .eng_crc(engCrc),
    .busy(busy), .frame_cnt(frameCnt), .err_cnt(errCnt)
  );

  crc16_frame_ctrl #(.MAX_WORDS(4)) dut4 (
    .clk(clk), .reset(reset),
    .s_valid(sValid), .s_ready(sReady4), .s_data(sData), .s_last(sLast), .mode(mode),
    .m_valid(mValid4), .m_ready(mReady), .m_crc(mCrc4), .m_err(mErr4),
    .eng_clear(engClear4), .eng_enable(engEnable4), .eng_data(engData4), .eng_crc(engCrc4),
    .busy(busy4), .frame_cnt(frameCnt4), .err_cnt(errCnt4)
  );

  // Stub engines: clear to zero, otherwise crc_next = crc ^ data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          engCrc <= '0;
    else if (engClear)  engCrc <= '0;
    else if (engEnable) engCrc <= engCrc ^ engData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           engCrc4 <= '0;
    else if (engClear4)  engCrc4 <= '0;
    else if (engEnable4) engCrc4 <= engCrc4 ^ engData4;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic last, input logic md);
    int waitCnt = 0;
    while (!sReady && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (!sReady) checkOutput("s_ready_timeout", {31'd0, sReady}, 32'd1);
    sValid = 1'b1;
    sData  = data;
    sLast  = last;
    mode   = md;
    #1;
    if (engEnable4) enCount4++;
    @(posedge clk);
    #1;
    sValid = 1'b0;
    sLast  = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [15:0] expCrc, input logic expErr);
    checkOutput({tag, "_settle_valid"}, {31'd0, mValid}, 32'd0);
    tick();
    checkOutput({tag, "_valid"}, {31'd0, mValid}, 32'd1);
    checkOutput({tag, "_crc"}, {16'd0, mCrc}, {16'd0, expCrc});
    checkOutput({tag, "_err"}, {31'd0, mErr}, {31'd0, expErr});
    checkOutput({tag, "_sready"}, {31'd0, sReady}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic handshake(input string tag, input logic [15:0] expFrames, input logic [15:0] expErrs);
    mReady = 1'b1;
    tick();
    mReady = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, mValid}, 32'd0);
    checkOutput({tag, "_clear"}, {31'd0, engClear}, 32'd1);
    checkOutput({tag, "_frame_cnt"}, {16'd0, frameCnt}, {16'd0, expFrames});
    checkOutput({tag, "_err_cnt"}, {16'd0, errCnt}, {16'd0, expErrs});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reset state");
    #2;
    checkOutput("rst_sready", {31'd0, sReady}, 32'd0);
    checkOutput("rst_mvalid", {31'd0, mValid}, 32'd0);
    checkOutput("rst_clear", {31'd0, engClear}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_frame_cnt", {16'd0, frameCnt}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("idle_sready", {31'd0, sReady}, 32'd1);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_clear", {31'd0, engClear}, 32'd0);

    $display("[TB] test 1: generate frame");
    applyStimulus(16'hABCD, 1'b0, 1'b0);
    checkOutput("t1_busy_after_first", {31'd0, busy}, 32'd1);
    applyStimulus(16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h8000, 1'b1, 1'b0);
    waitResult("t1", 16'hC606, 1'b0);
    handshake("t1", 16'd1, 16'd0);

    $display("[TB] test 2: check frames");
    applyStimulus(16'hABCD, 1'b0, 1'b1);
    applyStimulus(16'h1234, 1'b0, 1'b1);
    applyStimulus(16'hB9F9, 1'b1, 1'b1);
    waitResult("t2a", 16'hB9F9, 1'b0);
    handshake("t2a", 16'd2, 16'd0);
    applyStimulus(16'hABCD, 1'b0, 1'b1);
    applyStimulus(16'h1234, 1'b0, 1'b1);
    applyStimulus(16'hB9F8, 1'b1, 1'b1);
    waitResult("t2b", 16'hB9F9, 1'b1);
    handshake("t2b", 16'd3, 16'd1);

    $display("[TB] test 3: length overflow on MAX_WORDS=4 instance");
    enCount4 = 0;
    applyStimulus(16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0002, 1'b0, 1'b0);
    applyStimulus(16'h0004, 1'b0, 1'b0);
    applyStimulus(16'h0008, 1'b0, 1'b0);
    applyStimulus(16'h0010, 1'b0, 1'b0);
    applyStimulus(16'h0020, 1'b1, 1'b0);
    waitResult("t3", 16'h003F, 1'b0);
    checkOutput("t3_m4_valid", {31'd0, mValid4}, 32'd1);
    checkOutput("t3_m4_crc", {16'd0, mCrc4}, 32'h000F);
    checkOutput("t3_m4_err", {31'd0, mErr4}, 32'd1);
    checkOutput("t3_m4_enables", enCount4, 32'd4);
    handshake("t3", 16'd4, 16'd1);

    $display("[TB] single-word check frames");
    applyStimulus(16'h5A5A, 1'b1, 1'b1);
    waitResult("sw_bad", 16'h0000, 1'b1);
    handshake("sw_bad", 16'd5, 16'd2);
    applyStimulus(16'h0000, 1'b1, 1'b1);
    waitResult("sw_good", 16'h0000, 1'b0);
    handshake("sw_good", 16'd6, 16'd2);

    $display("[TB] test 4: result backpressure");
    applyStimulus(16'h0F0F, 1'b1, 1'b0);
    checkOutput("t4_settle_valid", {31'd0, mValid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", {31'd0, mValid}, 32'd1);
      checkOutput("t4_hold_crc", {16'd0, mCrc}, 32'h0F0F);
      checkOutput("t4_hold_err", {31'd0, mErr}, 32'd0);
      checkOutput("t4_hold_sready", {31'd0, sReady}, 32'd0);
      tick();
    end
    mReady = 1'b1;
    tick();
    mReady = 1'b0;
    checkOutput("t4_clear_pulse", {31'd0, engClear}, 32'd1);
    checkOutput("t4_clear_sready", {31'd0, sReady}, 32'd0);
    checkOutput("t4_clear_valid", {31'd0, mValid}, 32'd0);
    checkOutput("t4_frame_cnt", {16'd0, frameCnt}, 32'd7);
    tick();
    checkOutput("t4_accept_sready", {31'd0, sReady}, 32'd1);
    checkOutput("t4_accept_clear", {31'd0, engClear}, 32'd0);

    $display("[TB] test 5: async reset mid-frame");
    applyStimulus(16'h7777, 1'b0, 1'b0);
    applyStimulus(16'h8888, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t5_sready", {31'd0, sReady}, 32'd0);
    checkOutput("t5_clear", {31'd0, engClear}, 32'd1);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_mcrc", {16'd0, mCrc}, 32'd0);
    checkOutput("t5_frame_cnt", {16'd0, frameCnt}, 32'd0);
    checkOutput("t5_err_cnt", {16'd0, errCnt}, 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(16'h1111, 1'b0, 1'b0);
    applyStimulus(16'h2222, 1'b1, 1'b0);
    waitResult("t5", 16'h3333, 1'b0);
    handshake("t5", 16'd1, 16'd0);

    $display("[TB] test 6: mode change ignored after first beat");
    applyStimulus(16'h0005, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b1, 1'b1);
    mode = 1'b0;
    waitResult("t6", 16'h0006, 1'b0);
    handshake("t6", 16'd2, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
